// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer with a valid/ready byte holding register.
// Optional feature macro: UART_RX_PARITY_EN (even-parity checking).
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   input  logic        rx_ready,
   output logic [10:0] frame_out,
   output logic        def_en,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        parity_err,
   output logic        frame_err,
   output logic        overrun_err,
   output logic        busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      DEFRAME
   } state_t;

   state_t        state_q, state_d;
   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic [10:0]   frame_q, frame_d;
   logic          load_q;
   logic [7:0]    rx_data_q;
   logic          rx_valid_q;
   logic          ferr_q;
   logic          ovr_q;
   logic          accept;

   // Two-flop synchroniser plus one-cycle history for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   // Frame sequencer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         frame_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         frame_q   <= frame_d;
      end
   end

   // Next-state: start qualification at half bit, then full-bit sampling.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      frame_d   = frame_q;
      case (state_q)
         IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF) begin
               if (!rx_s2_q) begin
                  state_d    = DATA;
                  cnt_d      = '0;
                  bit_idx_d  = 4'd1;
                  frame_d[0] = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == FULL) begin
               for (int i = 1; i < 11; i++) begin
                  if (bit_idx_q == 4'(i)) frame_d[i] = rx_s2_q;
               end
               cnt_d     = '0;
               bit_idx_d = bit_idx_q + 4'd1;
               if (bit_idx_q == 4'd10) state_d = DEFRAME;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DEFRAME: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign def_en = (state_q == DEFRAME);
   assign busy   = (state_q != IDLE);

   // Load request lands in the cycle after the deframe strobe.
   always_ff @(posedge clk) begin
      if (rst) load_q <= 1'b0;
      else     load_q <= def_en;
   end

   assign accept = !rx_valid_q || rx_ready;

`ifdef UART_RX_PARITY_EN
   logic par_calc_q;
   logic perr_q;

   // Parity of the data field, captured while deframing.
   always_ff @(posedge clk) begin
      if (rst)         par_calc_q <= 1'b0;
      else if (def_en) par_calc_q <= ^frame_q[8:1];
   end

   // Parity flag follows the holding register's load/clear rules.
   always_ff @(posedge clk) begin
      if (rst)                       perr_q <= 1'b0;
      else if (load_q && accept)     perr_q <= frame_q[9] ^ par_calc_q;
      else if (rx_valid_q && rx_ready) perr_q <= 1'b0;
   end

   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   // Holding register: load, drop-on-overrun, and handshake clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else if (load_q) begin
         if (accept) begin
            rx_data_q  <= frame_q[8:1];
            ferr_q     <= ~frame_q[10];
            rx_valid_q <= 1'b1;
            ovr_q      <= 1'b0;
         end else begin
            ovr_q <= 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_q <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end
   end

   assign frame_out   = frame_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_err   = ferr_q;
   assign overrun_err = ovr_q;

endmodule
